// File: rtl/mux_scan_if.sv
// mux_scan_if: handshake and data bundle between mux_scan_ctrl and its environment.
// Optional macro MUX_SCAN_CONT_EN adds the `stop` request used by continuous scanning.
//
// Signal roles:
//   start  - scan request, acted on only while the sequencer is idle (level, no ready).
//   mask   - channel enables, captured together with an accepted start.
//   y      - mux output, combinational from s.
//   s      - registered mux select.
//   busy   - high while a channel is settling or being captured.
//   done   - single-cycle completion pulse, one per pass.
//   sample - captured y per channel; disabled channels read 0.
//   stop   - (continuous mode) ends scanning after the current pass.
interface mux_scan_if;
    logic       start;
    logic [3:0] mask;
    logic       y;
    logic [1:0] s;
    logic       busy;
    logic       done;
    logic [3:0] sample;
`ifdef MUX_SCAN_CONT_EN
    logic       stop;

    modport master (output start, mask, y, stop, input s, busy, done, sample);
    modport slave  (input start, mask, y, stop, output s, busy, done, sample);
`else
    modport master (output start, mask, y, input s, busy, done, sample);
    modport slave  (input start, mask, y, output s, busy, done, sample);
`endif
endinterface

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps a 4:1 mux select through the enabled channels in
// ascending order, waits DWELL settle cycles on each, then captures y.
// Optional macro MUX_SCAN_CONT_EN: repeat passes until `stop` is seen.
module mux_scan_ctrl #(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    mux_scan_if.slave  bus,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DWELL - 1);

    state_e           state_q, state_d;
    logic [1:0]       s_q, s_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       mask_q, mask_d;
    logic [3:0]       sample_q, sample_d;
`ifdef MUX_SCAN_CONT_EN
    logic             stop_q, stop_d;
`endif

    // Lowest set bit of m at or above position from; result is {found, index}.
    function automatic logic [2:0] first_from(input logic [3:0] m, input logic [1:0] from);
        logic [2:0] r;
        r = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            if (m[k] && (k >= int'(from))) begin
                r = {1'b1, 2'(k)};
            end
        end
        return r;
    endfunction

    logic [2:0] first_req;   // lowest channel of the incoming mask
    logic [2:0] next_ch;     // next enabled channel above the current select
    assign first_req = first_from(bus.mask, 2'd0);
    assign next_ch   = (s_q == 2'd3) ? 3'b000 : first_from(mask_q, s_q + 2'd1);
`ifdef MUX_SCAN_CONT_EN
    logic [2:0] first_lat;   // lowest channel of the latched mask, for the next pass
    assign first_lat = first_from(mask_q, 2'd0);
`endif

    // State and datapath registers; reset aborts any scan in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            s_q      <= 2'b00;
            cnt_q    <= '0;
            mask_q   <= 4'b0000;
            sample_q <= 4'b0000;
`ifdef MUX_SCAN_CONT_EN
            stop_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            sample_q <= sample_d;
`ifdef MUX_SCAN_CONT_EN
            stop_q   <= stop_d;
`endif
        end
    end

    // Next-state logic: select stepping, dwell counting and capture.
    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        cnt_d    = cnt_q;
        mask_d   = mask_q;
        sample_d = sample_q;
`ifdef MUX_SCAN_CONT_EN
        stop_d   = stop_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    // An empty mask is latched too so a later pass decision never sees a stale mask.
                    mask_d   = bus.mask;
                    sample_d = 4'b0000;
`ifdef MUX_SCAN_CONT_EN
                    stop_d   = 1'b0;
`endif
                    if (first_req[2]) begin
                        s_d     = first_req[1:0];
                        cnt_d   = CNT_RELOAD;
                        state_d = ST_SETTLE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_SETTLE: begin
`ifdef MUX_SCAN_CONT_EN
                stop_d = stop_q | bus.stop;
`endif
                if (cnt_q == '0) begin
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_CAPTURE: begin
`ifdef MUX_SCAN_CONT_EN
                stop_d = stop_q | bus.stop;
`endif
                sample_d[s_q] = bus.y;
                if (next_ch[2]) begin
                    s_d     = next_ch[1:0];
                    cnt_d   = CNT_RELOAD;
                    state_d = ST_SETTLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
`ifdef MUX_SCAN_CONT_EN
                // Another pass unless stop was seen at any point of this one.
                stop_d = 1'b0;
                if (!(stop_q || bus.stop) && first_lat[2]) begin
                    s_d     = first_lat[1:0];
                    cnt_d   = CNT_RELOAD;
                    state_d = ST_SETTLE;
                end else begin
                    state_d = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.s      = s_q;
    assign bus.busy   = (state_q == ST_SETTLE) || (state_q == ST_CAPTURE);
    assign bus.done   = (state_q == ST_DONE);
    assign bus.sample = sample_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: scoreboard bench for mux_scan_ctrl (default and MUX_SCAN_CONT_EN builds).
module tb_mux_scan_ctrl;
`ifdef MUX_SCAN_CONT_EN
    localparam int DWELL = 1;
`else
    localparam int DWELL = 4;
`endif

    // Clock and reset.
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mux_scan_if bus ();
    logic [1:0] dbg_state;
    logic [3:0] pattern;

    // Behavioural 4:1 mux: y follows the selected input bit.
    assign bus.y = pattern[bus.s];

    mux_scan_ctrl #(.DWELL(DWELL), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard queues.
    logic [3:0] exp_sample_q[$];
    logic [1:0] exp_s_q[$];
    int         exp_lat_q[$];
    int         exp_busy_q[$];

    int         cyc = 0;
    int         start_cyc = 0;
    int         done_cnt = 0;
    int         busy_run = 0;
    logic       prev_busy = 1'b0;
    logic [1:0] prev_s = 2'b00;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares select order, captured samples, latency and busy length.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.busy) begin
                busy_run++;
                if (!prev_busy || bus.s != prev_s) begin
                    if (exp_s_q.size() == 0) check("s_unexpected", 32'd1, 32'd0);
                    else check("s_seq", bus.s, exp_s_q.pop_front());
                end
            end
            if (bus.done) begin
                done_cnt++;
                check("busy_in_done", bus.busy, 1'b0);
                if (exp_sample_q.size() == 0) begin
                    check("done_unexpected", 32'd1, 32'd0);
                end else begin
                    check("sample", bus.sample, exp_sample_q.pop_front());
                    check("done_latency", cyc - start_cyc + 1, exp_lat_q.pop_front());
                    check("busy_cycles", busy_run, exp_busy_q.pop_front());
                end
                busy_run = 0;
            end
            prev_busy = bus.busy;
            prev_s    = bus.s;
        end
    end

    // Driver tasks.
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic expect_pass(input logic [3:0] m, input logic [3:0] pat, input int lat);
        int n;
        n = 0;
        for (int k = 0; k < 4; k++) begin
            if (m[k]) begin
                exp_s_q.push_back(2'(k));
                n++;
            end
        end
        exp_sample_q.push_back(m & pat);
        exp_lat_q.push_back(lat);
        exp_busy_q.push_back(n * (DWELL + 1));
    endtask

    function automatic int pass_len(input logic [3:0] m);
        int n;
        n = 0;
        for (int k = 0; k < 4; k++) if (m[k]) n++;
        return n * (DWELL + 1) + 1;
    endfunction

    // Called between clock edges with the DUT idle; returns just after the accepting edge.
    task automatic start_scan(input logic [3:0] m, input logic [3:0] pat);
        pattern = pat;
        expect_pass(m, pat, pass_len(m));
        bus.mask  = m;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        int b;
        b = budget;
        while (done_cnt < target && b > 0) begin
            step(1);
            b--;
        end
        if (done_cnt < target) check({tag, "_timeout"}, done_cnt, target);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [3:0] m;
        logic [3:0] p;
        bus.start = 1'b0;
        bus.mask  = 4'b0000;
        pattern   = 4'b0000;
`ifdef MUX_SCAN_CONT_EN
        bus.stop  = 1'b1;
`endif
        step(3);
        check("rst_s", bus.s, 2'b00);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_sample", bus.sample, 4'b0000);
        check("rst_state", dbg_state, 2'd0);
        rst_n = 1'b1;
        step(2);

        // Full scan.
        start_scan(4'b1111, 4'b1010);
        wait_done(1, 200, "full");
        step(3);
        check("full_idle", dbg_state, 2'd0);
        check("full_sample_hold", bus.sample, 4'b1010);

        // Sparse mask.
        start_scan(4'b0101, 4'b0111);
        wait_done(2, 200, "sparse");
        step(3);

        // Empty mask.
        start_scan(4'b0000, 4'b1111);
        wait_done(3, 50, "empty");
        step(3);
        check("empty_sample", bus.sample, 4'b0000);

        // Start and mask changes mid-scan, and start during DONE, are ignored.
        start_scan(4'b1001, 4'b1111);
        step(3);
        bus.start = 1'b1;
        bus.mask  = 4'b0110;
        step(1);
        bus.start = 1'b0;
        wait_done(4, 200, "ignored");
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        step(30);
        check("ignored_one_done", done_cnt, 4);
        check("ignored_idle", dbg_state, 2'd0);

        // Random scans.
        for (int r = 0; r < 4; r++) begin
            m = 4'($urandom_range(1, 15));
            p = 4'($urandom_range(0, 15));
            start_scan(m, p);
            wait_done(5 + r, 200, "random");
            step(2);
        end

        // Reset in the middle of a scan.
        base = done_cnt;
        start_scan(4'b1111, 4'b1111);
        step(6);
        rst_n = 1'b0;
        #1;
        check("midrst_s", bus.s, 2'b00);
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_sample", bus.sample, 4'b0000);
        exp_s_q.delete();
        exp_sample_q.delete();
        exp_lat_q.delete();
        exp_busy_q.delete();
        busy_run = 0;
        step(3);
        rst_n = 1'b1;
        step(40);
        check("midrst_no_done", done_cnt, base);

        // Recovery after reset.
        start_scan(4'b0110, 4'b0100);
        wait_done(base + 1, 200, "recover");
        step(3);

`ifdef MUX_SCAN_CONT_EN
        // Continuous passes, stopped during the second pass.
        base = done_cnt;
        bus.stop = 1'b0;
        pattern  = 4'b0010;
        expect_pass(4'b0011, 4'b0010, pass_len(4'b0011));
        expect_pass(4'b0011, 4'b0010, 2 * pass_len(4'b0011));
        bus.mask  = 4'b0011;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        bus.start = 1'b0;
        wait_done(base + 1, 100, "cont_pass1");
        step(2);
        bus.stop = 1'b1;
        step(1);
        bus.stop = 1'b0;
        wait_done(base + 2, 100, "cont_pass2");
        step(20);
        check("cont_two_done", done_cnt, base + 2);
        check("cont_busy", bus.busy, 1'b0);
        check("cont_idle", dbg_state, 2'd0);
`endif

        check("sb_drain", exp_sample_q.size() + exp_s_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
